// File: rtl/m_logic_pipe_pkg.sv
// Shared definitions for the pipelined bitwise logic unit: operation encodings.
package m_logic_pipe_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOT  = 3'd0,
        OP_AND  = 3'd1,
        OP_OR   = 3'd2,
        OP_XOR  = 3'd3,
        OP_NAND = 3'd4,
        OP_NOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_PASS = 3'd7
    } op_e;

endpackage

// File: rtl/m_logic_pipe_stage.sv
// One elastic pipeline register: holds a valid flag plus a WIDTH-bit payload and
// loads from upstream whenever the combined ready chain says this slot may move.
module m_logic_pipe_stage #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             dn_valid,
    output logic [WIDTH-1:0] dn_data
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Payload only changes on a real load so empty slots keep their last value.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_en) begin
            valid_d = up_valid;
            if (up_valid) begin
                data_d = up_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign dn_valid = valid_q;
    assign dn_data  = data_q;

endmodule

// File: rtl/m_logic_pipe.sv
// WIDTH-bit bitwise logic unit behind valid/ready, registered through STAGES
// elastic stages with full throughput and per-stage backpressure.
module m_logic_pipe
    import m_logic_pipe_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             busy
);

    logic [WIDTH-1:0] result;
    logic [STAGES-1:0] stage_vld;
    logic [STAGES:0]   rdy;
    logic [WIDTH:0]    stage_pay [STAGES];

    always_comb begin
        result = in_a;
        case (op_e'(in_op))
            OP_NOT:  result = ~in_a;
            OP_AND:  result = in_a & in_b;
            OP_OR:   result = in_a | in_b;
            OP_XOR:  result = in_a ^ in_b;
            OP_NAND: result = ~(in_a & in_b);
            OP_NOR:  result = ~(in_a | in_b);
            OP_XNOR: result = ~(in_a ^ in_b);
            OP_PASS: result = in_a;
            default: result = in_a;
        endcase
    end

    // Ready walks backwards from the consumer: a slot may load if it is empty or
    // its occupant is moving on this cycle. Only flop outputs feed this chain.
    always_comb begin
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = !stage_vld[k] || rdy[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic           up_valid;
        logic [WIDTH:0] up_data;

        if (k == 0) begin : g_first
            assign up_valid = in_valid;
            assign up_data  = {(result == '0), result};
        end else begin : g_next
            assign up_valid = stage_vld[k-1];
            assign up_data  = stage_pay[k-1];
        end

        m_logic_pipe_stage #(
            .WIDTH (WIDTH + 1)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .load_en  (rdy[k]),
            .up_valid (up_valid),
            .up_data  (up_data),
            .dn_valid (stage_vld[k]),
            .dn_data  (stage_pay[k])
        );
    end

    assign in_ready  = rdy[0];
    assign out_valid = stage_vld[STAGES-1];
    assign out_data  = stage_pay[STAGES-1][WIDTH-1:0];
    assign out_zero  = stage_pay[STAGES-1][WIDTH];
    assign busy      = |stage_vld;

endmodule

// File: tb/tb_m_logic_pipe.sv
// Bench for m_logic_pipe: three configurations (8/2, 1/1, 32/4) driven by directed
// tables, hand-written corner sequences and random traffic against a truth-table model.
module tb_m_logic_pipe;

    localparam int WD [3] = '{8, 1, 32};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        iv [3];
    logic        ordy [3];
    logic [2:0]  opv [3];
    logic [31:0] av [3];
    logic [31:0] bv [3];
    logic        ir [3];
    logic        ov [3];
    logic        oz [3];
    logic        bsy [3];
    logic [7:0]  od0;
    logic [0:0]  od1;
    logic [31:0] od2;
    logic [31:0] odw [3];

    assign odw[0] = {24'd0, od0};
    assign odw[1] = {31'd0, od1};
    assign odw[2] = od2;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          pops [3];
    logic [32:0] q [3][$];
    logic        held [3];
    logic [32:0] held_v [3];

    m_logic_pipe #(.WIDTH(8), .STAGES(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_op(opv[0]),
        .in_a(av[0][7:0]), .in_b(bv[0][7:0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_data(od0), .out_zero(oz[0]), .busy(bsy[0]));

    m_logic_pipe #(.WIDTH(1), .STAGES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_op(opv[1]),
        .in_a(av[1][0:0]), .in_b(bv[1][0:0]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_data(od1), .out_zero(oz[1]), .busy(bsy[1]));

    m_logic_pipe #(.WIDTH(32), .STAGES(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_op(opv[2]),
        .in_a(av[2]), .in_b(bv[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out_data(od2), .out_zero(oz[2]), .busy(bsy[2]));

    // Reference: each op is a 2-input truth table indexed by {a_bit, b_bit}.
    function automatic logic [32:0] ref_op(logic [2:0] op, logic [31:0] a, logic [31:0] b, int w);
        logic [3:0]  tt;
        logic [31:0] r;
        r = '0;
        case (op)
            3'd0:    tt = 4'b0011;
            3'd1:    tt = 4'b1000;
            3'd2:    tt = 4'b1110;
            3'd3:    tt = 4'b0110;
            3'd4:    tt = 4'b0111;
            3'd5:    tt = 4'b0001;
            3'd6:    tt = 4'b1001;
            default: tt = 4'b1100;
        endcase
        for (int i = 0; i < w; i++) r[i] = tt[{a[i], b[i]}];
        return {(r == 32'd0), r};
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic mon(int id);
        logic [32:0] e;
        if (rst_n !== 1'b1) begin
            q[id].delete();
            held[id] = 1'b0;
            return;
        end
        if (held[id]) chk($sformatf("hold_dut%0d", id), {ov[id], oz[id], odw[id]}, {1'b1, held_v[id]});
        if (ov[id] && ordy[id]) begin
            pops[id]++;
            if (q[id].size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_dut%0d: got output %0h with nothing expected", id, odw[id]);
            end else begin
                e = q[id].pop_front();
                chk($sformatf("scoreboard_dut%0d", id), {oz[id], odw[id]}, e);
            end
        end
        held[id]   = ov[id] && !ordy[id];
        held_v[id] = {oz[id], odw[id]};
        if (iv[id] && ir[id]) q[id].push_back(ref_op(opv[id], av[id], bv[id], WD[id]));
    endtask

    initial forever begin
        @(negedge clk);
        for (int id = 0; id < 3; id++) mon(id);
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       z;
    } vec_t;

    vec_t tbl [10];
    int   p0;

    initial begin
        tbl[0] = '{3'd0, 8'hA5, 8'h0F, 8'h5A, 1'b0};
        tbl[1] = '{3'd1, 8'hA5, 8'h0F, 8'h05, 1'b0};
        tbl[2] = '{3'd2, 8'hA5, 8'h0F, 8'hAF, 1'b0};
        tbl[3] = '{3'd3, 8'hA5, 8'h0F, 8'hAA, 1'b0};
        tbl[4] = '{3'd4, 8'hA5, 8'h0F, 8'hFA, 1'b0};
        tbl[5] = '{3'd5, 8'hA5, 8'h0F, 8'h50, 1'b0};
        tbl[6] = '{3'd6, 8'hA5, 8'h0F, 8'h55, 1'b0};
        tbl[7] = '{3'd7, 8'hA5, 8'h0F, 8'hA5, 1'b0};
        tbl[8] = '{3'd1, 8'hF0, 8'h0F, 8'h00, 1'b1};
        tbl[9] = '{3'd3, 8'h3C, 8'h3C, 8'h00, 1'b1};

        rst_n = 1'b0;
        for (int id = 0; id < 3; id++) begin
            iv[id] = 1'b0; ordy[id] = 1'b1; opv[id] = 3'd0; av[id] = '0; bv[id] = '0;
            pops[id] = 0; held[id] = 1'b0;
        end

        #2;
        for (int id = 0; id < 3; id++) begin
            chk($sformatf("reset_out_valid%0d", id), ov[id], 1'b0);
            chk($sformatf("reset_busy%0d", id), bsy[id], 1'b0);
            chk($sformatf("reset_in_ready%0d", id), ir[id], 1'b1);
            chk($sformatf("reset_out%0d", id), {oz[id], odw[id]}, 33'd0);
        end
        @(posedge clk); #1 rst_n = 1'b1;

        // Directed op table: exact latency and result per operation.
        for (int i = 0; i < 10; i++) begin
            iv[0] = 1'b1; opv[0] = tbl[i].op; av[0] = {24'd0, tbl[i].a}; bv[0] = {24'd0, tbl[i].b};
            @(posedge clk); #1;
            iv[0] = 1'b0;
            chk($sformatf("latency_early_%0d", i), ov[0], 1'b0);
            @(posedge clk); #1;
            chk($sformatf("latency_valid_%0d", i), ov[0], 1'b1);
            chk($sformatf("table_result_%0d", i), {oz[0], od0}, {tbl[i].z, tbl[i].d});
        end
        @(posedge clk); #1;

        // Backpressure: two beats fill the pipe, the third is refused until release.
        ordy[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iv[0] = 1'b1; opv[0] = 3'd3; av[0] = 32'h11 * (k + 1); bv[0] = 32'h0F;
            @(negedge clk);
            chk($sformatf("bp_in_ready_%0d", k), ir[0], (k < 2) ? 1'b1 : 1'b0);
            @(posedge clk); #1;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_full_in_ready", ir[0], 1'b0);
            chk("bp_full_out_valid", ov[0], 1'b1);
            chk("bp_full_busy", bsy[0], 1'b1);
            @(posedge clk); #1;
        end
        p0 = pops[0];
        ordy[0] = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", ir[0], 1'b1);
        @(posedge clk); #1 iv[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_delivered", pops[0] - p0, 3);
        chk("bp_queue_empty", q[0].size(), 0);
        chk("bp_busy_idle", bsy[0], 1'b0);

        // Streaming: 16 back-to-back beats, results on 16 consecutive cycles.
        for (int j = 0; j < 19; j++) begin
            if (j < 16) begin
                iv[0] = 1'b1; opv[0] = 3'd3; av[0] = $urandom; bv[0] = $urandom;
            end else begin
                iv[0] = 1'b0;
            end
            @(negedge clk);
            if (j < 16) chk($sformatf("stream_in_ready_%0d", j), ir[0], 1'b1);
            chk($sformatf("stream_out_valid_%0d", j), ov[0], (j >= 2 && j <= 17) ? 1'b1 : 1'b0);
            @(posedge clk); #1;
        end

        // Asynchronous reset with two beats in flight.
        ordy[0] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            iv[0] = 1'b1; opv[0] = 3'd0; av[0] = 32'h0C + k; bv[0] = '0;
            @(posedge clk); #1;
        end
        iv[0] = 1'b0;
        chk("midreset_pre_out_valid", ov[0], 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", ov[0], 1'b0);
        chk("midreset_busy", bsy[0], 1'b0);
        chk("midreset_out", {oz[0], od0}, 9'd0);
        chk("midreset_in_ready", ir[0], 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        chk("postreset_out_valid", ov[0], 1'b0);

        // Random traffic with random consumer stalls on all configurations.
        for (int c = 0; c < 600; c++) begin
            for (int id = 0; id < 3; id++) begin
                iv[id]   = ($urandom_range(0, 3) != 0);
                opv[id]  = 3'($urandom_range(0, 7));
                av[id]   = $urandom;
                bv[id]   = ($urandom_range(0, 7) == 0) ? av[id] : $urandom;
                ordy[id] = ($urandom_range(0, 1) != 0);
            end
            @(posedge clk); #1;
        end
        for (int id = 0; id < 3; id++) begin
            iv[id] = 1'b0; ordy[id] = 1'b1;
        end
        repeat (8) @(posedge clk);
        #1;
        for (int id = 0; id < 3; id++) begin
            chk($sformatf("drain_queue%0d", id), q[id].size(), 0);
            chk($sformatf("drain_busy%0d", id), bsy[id], 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
